// File: rtl/core_apb_lsram_pkg.sv
// Shared constants and elaboration-time helpers for the APB scratch SRAM.
package core_apb_lsram_pkg;

  localparam int SRAM_LSRAM = 0;
  localparam int SRAM_USRAM = 1;
  localparam int APB_AWIDTH = 20;

  // Byte-to-word address shift for the legal APB data widths (8, 16, 32).
  function automatic int calc_shift(input int dwidth);
    int sh;
    case (dwidth)
      8:       sh = 0;
      16:      sh = 1;
      default: sh = 2;
    endcase
    return sh;
  endfunction

  function automatic int calc_depth(input int sram_type, input int lsram_depth,
                                    input int usram_depth);
    return (sram_type == SRAM_LSRAM) ? lsram_depth : usram_depth;
  endfunction

endpackage

// File: rtl/core_apb_lsram_mem.sv
// Behavioural single-port RAM with registered read data that holds when no read is issued.
module core_apb_lsram_mem
  import core_apb_lsram_pkg::*;
#(
  parameter int SRAM_TYPE = SRAM_LSRAM,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2048,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Separate branches keep the macro flavour visible in the hierarchy for mapping.
  if (SRAM_TYPE == SRAM_USRAM) begin : g_usram
    always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
    end
  end else begin : g_lsram
    always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/core_apb_lsram.sv
// Zero-wait-state APB3 slave exposing an on-chip SRAM as a flat byte-addressed window.
module core_apb_lsram
  import core_apb_lsram_pkg::*;
#(
  parameter int SEL_SRAM_TYPE              = 0,
  parameter int APB_DWIDTH                 = 32,
  parameter int LSRAM_NUM_LOCATIONS_DWIDTH = 2048,
  parameter int USRAM_NUM_LOCATIONS_DWIDTH = 512
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_AWIDTH-1:0] PADDR,
  input  logic [APB_DWIDTH-1:0] PWDATA,
  output logic [APB_DWIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int DEPTH = calc_depth(SEL_SRAM_TYPE, LSRAM_NUM_LOCATIONS_DWIDTH,
                                    USRAM_NUM_LOCATIONS_DWIDTH);
  localparam int SHIFT = calc_shift(APB_DWIDTH);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [APB_AWIDTH-1:0] DEPTH_A = APB_AWIDTH'(DEPTH);

  logic                  rd_setup, wr_access, in_range;
  logic [APB_AWIDTH-1:0] idx;
  logic                  rd_hit_q, rd_hit_d;
  logic [APB_DWIDTH-1:0] mem_rdata;

  assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;
  assign wr_access = PSEL &  PENABLE &  PWRITE;
  assign idx       = PADDR >> SHIFT;
  assign in_range  = (idx < DEPTH_A);

  core_apb_lsram_mem #(
    .SRAM_TYPE (SEL_SRAM_TYPE),
    .DATA_W    (APB_DWIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk_i   (PCLK),
    .we_i    (PRESETN & wr_access & in_range),
    .waddr_i (idx[AW-1:0]),
    .wdata_i (PWDATA),
    .re_i    (PRESETN & rd_setup & in_range),
    .raddr_i (idx[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // RAM read data is unreset; this flag masks it to zero after reset or an out-of-range read.
  always_comb begin
    rd_hit_d = rd_hit_q;
    if (rd_setup) rd_hit_d = in_range;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETN) rd_hit_q <= 1'b0;
    else          rd_hit_q <= rd_hit_d;
  end

  assign PRDATA  = rd_hit_q ? mem_rdata : '0;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

endmodule

// File: tb/tb_core_apb_lsram.sv
// Randomized self-checking bench: a 32-bit LSRAM instance and an 8-bit uSRAM instance on one APB bus.
module tb_core_apb_lsram;

  localparam int DEPTH_A = 2048;
  localparam int DEPTH_B = 512;

  logic        PCLK = 1'b0;
  logic        PRESETN, PSEL, PENABLE, PWRITE;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] prdata_a;
  logic [7:0]  prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mdl_a [int];
  logic [7:0]  mdl_b [int];

  always #5 PCLK = ~PCLK;

  core_apb_lsram #(
    .SEL_SRAM_TYPE(0), .APB_DWIDTH(32),
    .LSRAM_NUM_LOCATIONS_DWIDTH(DEPTH_A), .USRAM_NUM_LOCATIONS_DWIDTH(DEPTH_B)
  ) dut_a (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
  );

  core_apb_lsram #(
    .SEL_SRAM_TYPE(1), .APB_DWIDTH(8),
    .LSRAM_NUM_LOCATIONS_DWIDTH(DEPTH_A), .USRAM_NUM_LOCATIONS_DWIDTH(DEPTH_B)
  ) dut_b (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA[7:0]), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference model: word index is byte address divided by bytes per word.
  function automatic void mdl_write(input logic [19:0] a, input logic [31:0] d);
    int ia = int'(a) / 4;
    int ib = int'(a);
    if (ia < DEPTH_A) mdl_a[ia] = d;
    if (ib < DEPTH_B) mdl_b[ib] = d[7:0];
  endfunction

  task automatic check_read(input string tag, input logic [19:0] a);
    int ia = int'(a) / 4;
    int ib = int'(a);
    if (ia >= DEPTH_A)         chk({tag, "_a"}, prdata_a, 32'h0);
    else if (mdl_a.exists(ia)) chk({tag, "_a"}, prdata_a, mdl_a[ia]);
    if (ib >= DEPTH_B)         chk({tag, "_b"}, {24'h0, prdata_b}, 32'h0);
    else if (mdl_b.exists(ib)) chk({tag, "_b"}, {24'h0, prdata_b}, {24'h0, mdl_b[ib]});
  endtask

  task automatic apb_write(input logic [19:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    mdl_write(a, d);
  endtask

  task automatic apb_read(input string tag, input logic [19:0] a);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    check_read(tag, a);
    PENABLE = 1'b1;
    @(posedge PCLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
    end
  endtask

  initial begin
    logic [19:0] ra;
    PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_prdata_a", prdata_a, 32'h0);
    chk("rst_prdata_b", {24'h0, prdata_b}, 32'h0);
    chk("rst_pready_a", {31'h0, pready_a}, 32'h1);
    chk("rst_pready_b", {31'h0, pready_b}, 32'h1);
    chk("rst_pslverr_a", {31'h0, pslverr_a}, 32'h0);
    chk("rst_pslverr_b", {31'h0, pslverr_b}, 32'h0);
    PRESETN = 1'b1;

    // Byte-granular sweep fills the 8-bit instance, then word sweep fills the 32-bit one.
    for (int a = 0; a < DEPTH_B; a++) apb_write(20'(a), 32'(a) + (32'(a) << 16));
    for (int a = 0; a < 4 * DEPTH_A; a += 4) apb_write(20'(a), 32'(a) + (32'(a) << 16));
    for (int a = 0; a < 4 * DEPTH_A; a += 4) apb_read("sweep", 20'(a));
    for (int a = 0; a < DEPTH_B; a++) apb_read("sweep8", 20'(a));

    apb_read("hold_rd", 20'h4);
    chk("hold_const_a", prdata_a, 32'h0004_0004);
    chk("hold_const_b", {24'h0, prdata_b}, 32'h04);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("hold_idle", prdata_a, 32'h0004_0004);
    end
    apb_write(20'h8, $urandom);
    idle(1);
    chk("hold_after_wr_a", prdata_a, 32'h0004_0004);
    chk("hold_after_wr_b", {24'h0, prdata_b}, 32'h04);

    apb_write(20'(4 * DEPTH_A), 32'hDEAD_BEEF);
    @(negedge PCLK);
    chk("oor_pslverr_a", {31'h0, pslverr_a}, 32'h0);
    apb_read("oor_rd", 20'(4 * DEPTH_A));
    chk("oor_rd_const", prdata_a, 32'h0);
    apb_read("oor_loc0", 20'h0);
    apb_read("oor_last", 20'(4 * DEPTH_A - 4));
    apb_read("oor_b_loc0", 20'h1);

    apb_write(20'h10, 32'h11);
    apb_read("pre_rst", 20'h10);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'h10; PWDATA = 32'h55;
    @(negedge PCLK);
    PENABLE = 1'b1; PRESETN = 1'b0;
    @(negedge PCLK);
    chk("midrst_prdata_a", prdata_a, 32'h0);
    chk("midrst_prdata_b", {24'h0, prdata_b}, 32'h0);
    chk("midrst_pready", {31'h0, pready_a}, 32'h1);
    chk("midrst_pslverr", {31'h0, pslverr_a}, 32'h0);
    PRESETN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    idle(1);
    chk("post_rst_prdata", prdata_a, 32'h0);
    apb_read("post_rst_rd", 20'h10);
    chk("post_rst_const", prdata_a, 32'h11);

    repeat (400) begin
      ra = 20'($urandom_range(0, 4 * DEPTH_A + 255));
      if ($urandom_range(0, 1) == 1) apb_write(ra, $urandom);
      else                           apb_read("rnd", ra);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
